// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port arbiter sharing one single-port memory between the CPU
//            core and a debug/loader host. Grants are combinational and use
//            round-robin on ties. The host can take exclusive ownership by
//            holding host_lock. Read data returns one cycle after a read
//            grant and is steered to the requester that issued the read.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU access request (held stable until granted)
//   cpu_gnt               CPU access issued to memory this cycle
//   cpu_rvalid/rdata      CPU read data return
//   cpu_stall             CPU request pending without a grant
//   host_req/we/addr/wdata host access request (held stable until granted)
//   host_lock             host requests exclusive ownership of memory
//   host_gnt              host access issued to memory this cycle
//   host_rvalid/rdata     host read data return
//   mem_en/we/addr/wdata  memory strobe, write enable, address, write data
//   mem_rdata             memory read data, one cycle after a read strobe
//   locked                arbiter is in the host-exclusive state
// ============================================================================
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clock,
   input  logic          reset_n,
   // CPU port
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   // Host port
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   input  logic          host_lock,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   // Memory port
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   // Status
   output logic          locked
);

   typedef enum logic [0:0] {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Encoding for last_win and rd_owner
   localparam logic WIN_CPU  = 1'b0;
   localparam logic WIN_HOST = 1'b1;

   state_t state_q, state_d;
   logic   last_win_q, last_win_d;
   logic   rd_valid_q, rd_valid_d;
   logic   rd_owner_q, rd_owner_d;

   logic   cpu_gnt_c;
   logic   host_gnt_c;

   // ------------------------------------------------------------------------
   // Grant decision. Gated by reset_n so every output is low while reset is
   // asserted, even though grants are purely combinational.
   // ------------------------------------------------------------------------
   always_comb begin
      cpu_gnt_c  = 1'b0;
      host_gnt_c = 1'b0;
      if (reset_n) begin
         if (state_q == ST_LOCKED) begin
            host_gnt_c = host_req;
         end else if (cpu_req && host_req) begin
            // Tie: the side that did not win most recently goes first
            if (last_win_q == WIN_HOST) begin
               cpu_gnt_c = 1'b1;
            end else begin
               host_gnt_c = 1'b1;
            end
         end else begin
            cpu_gnt_c  = cpu_req;
            host_gnt_c = host_req;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      last_win_d = last_win_q;

      if (cpu_gnt_c) begin
         last_win_d = WIN_CPU;
      end else if (host_gnt_c) begin
         last_win_d = WIN_HOST;
      end

      case (state_q)
         ST_ARB: begin
            // Lock takes effect at this edge even if the CPU was granted now
            if (host_lock) begin
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (!host_lock) begin
               state_d    = ST_ARB;
               // Favour the CPU, which has been starved during the lock
               last_win_d = WIN_HOST;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase

      rd_valid_d = (cpu_gnt_c && !cpu_we) || (host_gnt_c && !host_we);
      rd_owner_d = host_gnt_c ? WIN_HOST : WIN_CPU;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_ARB;
         last_win_q <= WIN_HOST;
         rd_valid_q <= 1'b0;
         rd_owner_q <= WIN_CPU;
      end else begin
         state_q    <= state_d;
         last_win_q <= last_win_d;
         rd_valid_q <= rd_valid_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // ------------------------------------------------------------------------
   // Memory request mux: all fields are zero when nobody is granted
   // ------------------------------------------------------------------------
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt_c) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (host_gnt_c) begin
         mem_en    = 1'b1;
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign cpu_gnt     = cpu_gnt_c;
   assign host_gnt    = host_gnt_c;
   assign cpu_stall   = reset_n && cpu_req && !cpu_gnt_c;
   assign cpu_rvalid  = rd_valid_q && (rd_owner_q == WIN_CPU);
   assign host_rvalid = rd_valid_q && (rd_owner_q == WIN_HOST);
   assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
   assign host_rdata  = host_rvalid ? mem_rdata : '0;
   assign locked      = (state_q == ST_LOCKED);

endmodule
`default_nettype wire
